// File: rtl/mem_stage_lsu.sv
// RV32I memory-stage load/store unit: turns M-stage loads/stores into a req/ack
// bus transaction, stalls the pipeline while it is outstanding and extends load data.
module mem_stage_lsu #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [2:0]        funct3M,
    input  logic [ADDR_W-1:0] ALUResultM,
    input  logic [31:0]       WriteDataM,
    output logic [31:0]       ReadDataM,
    output logic              StallM,
    output logic              MisalignM,
    output logic              BusErrM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic [2:0]        funct3_q;
    logic [1:0]        lane_q;
    logic [31:0]       rdata_q;
    logic              buserr_q;

    logic              access;
    logic [1:0]        size;
    logic [1:0]        lane;
    logic              misalign;
    logic [3:0]        be_d;
    logic [31:0]       wdata_d;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_ext;

    assign lane   = ALUResultM[1:0];
    assign access = MemReadM | MemWriteM;

    // size: 0 = byte, 1 = half, 2 = word; stores only know B/H/W, everything else is a word
    always_comb begin
        size = 2'd2;
        case (funct3M)
            3'b000:  size = 2'd0;
            3'b001:  size = 2'd1;
            3'b100:  size = MemWriteM ? 2'd2 : 2'd0;
            3'b101:  size = MemWriteM ? 2'd2 : 2'd1;
            default: size = 2'd2;
        endcase

        misalign = access && (((size == 2'd1) && lane[0]) || ((size == 2'd2) && (lane != 2'b00)));

        be_d    = 4'b1111;
        wdata_d = WriteDataM;
        case (size)
            2'd0: begin
                be_d    = 4'b0001 << lane;
                wdata_d = {4{WriteDataM[7:0]}};
            end
            2'd1: begin
                be_d    = 4'b0011 << lane;
                wdata_d = {2{WriteDataM[15:0]}};
            end
            default: ;
        endcase
    end

    // Load extension works on the lane latched at issue, since the M-stage inputs may move on
    always_comb begin
        byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
        half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'h0, byte_sel};
            3'b101:  load_ext = {16'h0, half_sel};
            default: load_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        StallM     = 1'b0;
        MisalignM  = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_be     = '0;
        mem_wdata  = '0;
        ReadDataM  = '0;
        BusErrM    = 1'b0;
        case (state)
            IDLE: begin
                MisalignM = misalign;
                if (access && !misalign) begin
                    StallM     = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                mem_req   = 1'b1;
                StallM    = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_be    = be_q;
                mem_wdata = wdata_q;
                if (mem_ack || (cnt == CNT_LAST)) state_next = DONE;
            end
            DONE: begin
                ReadDataM  = rdata_q;
                BusErrM    = buserr_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // The IDLE decode is combinational on the inputs, so it must be silenced during reset
        if (!reset) begin
            StallM    = 1'b0;
            MisalignM = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            addr_q   <= '0;
            be_q     <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            funct3_q <= '0;
            lane_q   <= '0;
            rdata_q  <= '0;
            buserr_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (access && !misalign) begin
                        addr_q   <= {ALUResultM[ADDR_W-1:2], 2'b00};
                        be_q     <= be_d;
                        we_q     <= MemWriteM;
                        wdata_q  <= wdata_d;
                        funct3_q <= funct3M;
                        lane_q   <= lane;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + CNT_W'(1);
                    if (mem_ack) begin
                        rdata_q  <= we_q ? 32'h0 : load_ext;
                        buserr_q <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        rdata_q  <= 32'h0;
                        buserr_q <= 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end
endmodule
